// File: rtl/pow_n_pkg.sv
// Shared types and arithmetic helpers for the streaming x^N pipeline.
// Optional overflow tracking is enabled with the POW_N_OVF_EN macro.
package pow_n_pkg;

    localparam int N_DEF     = 5;
    localparam int W_IN_DEF  = 8;
    localparam int W_RES_DEF = 32;
    localparam int STAGES    = N_DEF - 1;

    // Stage payload is sized for the widest supported build (W_IN <= 32, W_RES <= 64).
    // Unused upper bits stay zero and are pruned by synthesis.
    localparam int X_MAX   = 32;
    localparam int ACC_MAX = 64;
    localparam int P_W     = X_MAX + ACC_MAX;

    typedef struct packed {
        logic               v;
        logic [X_MAX-1:0]   x;
        logic [ACC_MAX-1:0] acc;
`ifdef POW_N_OVF_EN
        logic               ovf;
`endif
    } stage_t;

    function automatic logic [P_W-1:0] mul_full(input logic [ACC_MAX-1:0] a,
                                                input logic [X_MAX-1:0]   b);
        return {{X_MAX{1'b0}}, a} * {{ACC_MAX{1'b0}}, b};
    endfunction

    // Product of a and b reduced modulo 2^w.
    function automatic logic [ACC_MAX-1:0] mul_trunc(input logic [ACC_MAX-1:0] a,
                                                     input logic [X_MAX-1:0]   b,
                                                     input int                 w);
        logic [ACC_MAX-1:0] mask;
        mask = (w >= ACC_MAX) ? '1 : ((ACC_MAX'(1) << w) - ACC_MAX'(1));
        return ACC_MAX'(mul_full(a, b)) & mask;
    endfunction

    // True when the exact product has any bit at position w or above.
    function automatic logic prod_ovf(input logic [ACC_MAX-1:0] a,
                                      input logic [X_MAX-1:0]   b,
                                      input int                 w);
        return (mul_full(a, b) >> w) != '0;
    endfunction

endpackage

// File: rtl/pow_n_stage.sv
// One register stage of the x^N pipeline: multiplies the incoming accumulator by x
// and holds its contents whenever the downstream stage cannot take them.
module pow_n_stage
    import pow_n_pkg::*;
#(
    parameter int W_RES = W_RES_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t prev,
    input  logic   next_rdy,
    output logic   rdy,
    output stage_t cur
);

    // An empty stage always accepts, so bubbles are squeezed out under backpressure.
    assign rdy = !cur.v || next_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur.v <= 1'b0;
`ifdef POW_N_OVF_EN
            cur.ovf <= 1'b0;
`endif
        end else if (rdy) begin
            cur.v   <= prev.v;
            cur.x   <= prev.x;
            cur.acc <= mul_trunc(prev.acc, prev.x, W_RES);
`ifdef POW_N_OVF_EN
            cur.ovf <= prev.ovf | prod_ovf(prev.acc, prev.x, W_RES);
`endif
        end
    end

endmodule

// File: rtl/pow_n_pipelined_ready.sv
// Streaming x^N engine: N-1 multiply stages, one operand in and one result out per cycle.
// Defining POW_N_OVF_EN adds a sticky overflow flag that travels with each result (out_ovf).
module pow_n_pipelined_ready
    import pow_n_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W_IN  = W_IN_DEF,
    parameter int W_RES = W_RES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_RES-1:0] out_data
`ifdef POW_N_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int DEPTH = N - 1;

    // Handshake: a word moves across a boundary on a posedge where valid && ready.
    // The ready chain runs combinationally from out_ready back to in_ready.
    stage_t head;
    stage_t st  [1:DEPTH];
    logic   rdy [1:DEPTH];

    // Stage 1 sees acc = x, so its multiply forms x*x.
    always_comb begin
        head     = '0;
        head.v   = in_valid;
        head.x   = X_MAX'(in_data);
        head.acc = ACC_MAX'(in_data);
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        stage_t prev_s;
        logic   nrdy;

        if (k == 1) begin : g_first
            assign prev_s = head;
        end else begin : g_chain
            assign prev_s = st[k-1];
        end

        if (k == DEPTH) begin : g_last
            assign nrdy = out_ready;
        end else begin : g_inner
            assign nrdy = rdy[k+1];
        end

        pow_n_stage #(
            .W_RES(W_RES)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .prev    (prev_s),
            .next_rdy(nrdy),
            .rdy     (rdy[k]),
            .cur     (st[k])
        );
    end

    assign in_ready  = rdy[1];
    assign out_valid = st[DEPTH].v;
    assign out_data  = st[DEPTH].acc[W_RES-1:0];
`ifdef POW_N_OVF_EN
    assign out_ovf   = st[DEPTH].ovf;
`endif

    logic unused_bits;
    assign unused_bits = ^{st[DEPTH].x, st[DEPTH].acc};

endmodule

// File: tb/tb_pow_n_pipelined_ready.sv
// Self-checking bench for pow_n_pipelined_ready: directed scenarios plus a random stream
// scored against an arithmetic x^N model.
module tb_pow_n_pipelined_ready;

    localparam int N    = 5;
    localparam int W_IN = 8;
`ifdef POW_N_OVF_EN
    localparam int W_RES = 8;
`else
    localparam int W_RES = 32;
`endif
    localparam int W_EXP = W_RES + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W_IN-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W_RES-1:0] out_data;
`ifdef POW_N_OVF_EN
    logic             out_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W_EXP-1:0] exp_q[$];

    pow_n_pipelined_ready #(
        .N(N), .W_IN(W_IN), .W_RES(W_RES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef POW_N_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Exact x^N in 64 bits, then reduced: {overflow, x^N mod 2^W_RES}.
    function automatic logic [W_EXP-1:0] model(input logic [W_IN-1:0] x);
        longint unsigned full;
        full = 1;
        for (int i = 0; i < N; i++) full = full * 64'(x);
        return {((full >> W_RES) != 0), W_RES'(full)};
    endfunction

    function automatic logic [W_RES-1:0] model_data(input logic [W_IN-1:0] x);
        logic [W_EXP-1:0] m;
        m = model(x);
        return m[W_RES-1:0];
    endfunction

    // Scoreboard: observe both handshakes at negedge, when inputs and outputs are settled.
    always @(negedge clk) begin
        logic [W_EXP-1:0] e;
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: out_data=%0d popped, required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e[W_RES-1:0]) begin
                        n_fail++;
                        $display("FAIL sb_data: out_data=%0d, required %0d", out_data, e[W_RES-1:0]);
                    end
`ifdef POW_N_OVF_EN
                    n_checks++;
                    if (out_ovf !== e[W_RES]) begin
                        n_fail++;
                        $display("FAIL sb_ovf: out_ovf=%0b, required %0b", out_ovf, e[W_RES]);
                    end
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
    end

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: out_valid=%0b, required 0", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: in_ready=%0b, required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        int   cnt;
        logic rdy_ok;
        rdy_ok = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'd3; out_ready = 1'b1;
        if (!in_ready) rdy_ok = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = W_IN'($urandom);
            cnt++;
            if (!in_ready) rdy_ok = 1'b0;
        end while (!out_valid && cnt < 20);
        n_checks++;
        if (cnt != 4) begin
            n_fail++; $display("FAIL latency_cycles: out_valid after %0d cycles, required 4", cnt);
        end
        n_checks++;
        if (out_data !== model_data(8'd3)) begin
            n_fail++; $display("FAIL latency_data: out_data=%0d, required %0d", out_data, model_data(8'd3));
        end
        n_checks++;
        if (rdy_ok !== 1'b1) begin
            n_fail++; $display("FAIL latency_in_ready: in_ready dropped, required always 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W_RES-1:0] got [4];
        int gcyc [4];
        int ng;
        ng = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1; in_data = W_IN'(i + 1);
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (out_valid && ng < 4) begin
                        got[ng] = out_data; gcyc[ng] = c; ng++;
                    end
                end
            end
        join
        n_checks++;
        if (ng != 4) begin
            n_fail++; $display("FAIL b2b_count: %0d results, required 4", ng);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got[i] !== model_data(W_IN'(i + 1)) || gcyc[i] != gcyc[0] + i) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: data=%0d at cycle %0d, required %0d at cycle %0d",
                             i, got[i], gcyc[i], model_data(W_IN'(i + 1)), gcyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W_IN-1:0]  d [6];
        logic [W_RES-1:0] held;
        logic held_v, stable, took;
        int accepts, idx, guard;
        foreach (d[i]) d[i] = W_IN'($urandom);
        held = '0; held_v = 1'b0; stable = 1'b1; accepts = 0; idx = 0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = d[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = in_ready;
            if (took) accepts++;
            if (out_valid) begin
                if (!held_v) begin held = out_data; held_v = 1'b1; end
                else if (out_data !== held) stable = 1'b0;
            end
            @(posedge clk); #1;
            if (took) begin idx++; in_data = d[idx]; end
        end
        @(negedge clk);
        n_checks++;
        if (accepts != 4) begin
            n_fail++; $display("FAIL bp_accepts: %0d accepted while stalled, required 4", accepts);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready: in_ready=%0b when full, required 0", in_ready);
        end
        n_checks++;
        if (!held_v || !stable || held !== model_data(d[0])) begin
            n_fail++;
            $display("FAIL bp_hold: held=%0d valid=%0b stable=%0b, required %0d valid and stable",
                     held, held_v, stable, model_data(d[0]));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        guard = 0;
        while (idx < 6 && guard < 20) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            guard++;
            if (took) begin
                idx++;
                if (idx < 6) in_data = d[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        n_checks++;
        if (exp_q.size() != 0 || idx != 6) begin
            n_fail++;
            $display("FAIL bp_drain: %0d results pending, %0d pushed, required 0 pending and 6 pushed",
                     exp_q.size(), idx);
        end
    endtask

    task automatic test_bubbles();
        logic [W_RES-1:0] got [2];
        int gcyc [2];
        int ng;
        ng = 0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd2;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; in_valid = 1'b1; in_data = 8'd5;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && ng < 2) begin got[ng] = out_data; gcyc[ng] = c; ng++; end
        end
        n_checks++;
        if (ng != 2 || got[0] !== model_data(8'd2) || got[1] !== model_data(8'd5) || gcyc[1] != gcyc[0] + 1) begin
            n_fail++;
            $display("FAIL bubbles: n=%0d data %0d,%0d cycles %0d,%0d, required %0d,%0d adjacent",
                     ng, got[0], got[1], gcyc[0], gcyc[1], model_data(8'd2), model_data(8'd5));
        end
    endtask

    task automatic test_reset_midop();
        logic stale;
        int   cnt;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = W_IN'($urandom_range(2, 255));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_out_valid: out_valid=%0b after reset, required 0", out_valid);
        end
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stale: stale out_valid seen, required none");
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'd2;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0; cnt++;
        end while (!out_valid && cnt < 20);
        n_checks++;
        if (cnt != 4 || out_data !== model_data(8'd2)) begin
            n_fail++;
            $display("FAIL midrst_fresh: data=%0d after %0d cycles, required %0d after 4",
                     out_data, cnt, model_data(8'd2));
        end
        @(posedge clk); #1;
    endtask

`ifdef POW_N_OVF_EN
    task automatic test_ovf();
        logic [W_IN-1:0]  xs   [2];
        logic [W_RES-1:0] eds  [2];
        logic             eov  [2];
        int cnt;
        xs[0] = 8'd3; eds[0] = 8'd243; eov[0] = 1'b0;
        xs[1] = 8'd4; eds[1] = 8'd0;   eov[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1; in_valid = 1'b1; in_data = xs[i];
            cnt = 0;
            do begin
                @(posedge clk); #1;
                in_valid = 1'b0; cnt++;
            end while (!out_valid && cnt < 20);
            n_checks++;
            if (!out_valid || out_data !== eds[i] || out_ovf !== eov[i]) begin
                n_fail++;
                $display("FAIL ovf_x%0d: valid=%0b data=%0d ovf=%0b, required data=%0d ovf=%0b",
                         xs[i], out_valid, out_data, out_ovf, eds[i], eov[i]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_random();
        int guard;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W_IN'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        n_checks++;
        if (exp_q.size() != 0 || out_valid) begin
            n_fail++;
            $display("FAIL random_drain: %0d results missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_midop();
`ifdef POW_N_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
